// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frames 2048 ADC samples into four 512-deep FFT banks, launches the FFT and streams results back out.
// Optional build macro FFT_FRAME_OVF_CNT_EN enables the saturating dropped-sample counter on oOVF_CNT.
// oOUT_DATA is the incoming RAM data steered by a registered bank select, so oOUT_VALID lands exactly RD_LAT cycles after oRE.
module fft_frame_ctrl #(
    parameter int RD_LAT = 2
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic [15:0] iDATA,
    input  logic        iVALID,
    output logic        oREADY,
    output logic [15:0] oDATA,
    output logic [8:0]  oADDR_WR,
    output logic [3:0]  oWE,
    output logic        oSTART,
    input  logic        iFFT_RDY,
    output logic [8:0]  oADDR_RD,
    output logic [3:0]  oRE,
    input  logic [15:0] iRD_DATA_0,
    input  logic [15:0] iRD_DATA_1,
    input  logic [15:0] iRD_DATA_2,
    input  logic [15:0] iRD_DATA_3,
    output logic [15:0] oOUT_DATA,
    output logic        oOUT_VALID,
    output logic        oOUT_LAST,
    output logic        oBUSY,
    output logic [15:0] oOVF_CNT
);
    typedef enum logic [2:0] {LOAD, START, WAIT_FFT, UNLOAD, DRAIN} state_t;
    state_t state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic accept, rd_issue, rdy_prev_q;
    logic ready_q, busy_q, start_q, rd_last_q;
    logic [15:0] data_q;
    logic [8:0] addr_wr_q, addr_rd_q;
    logic [3:0] we_q, re_q;
    logic [1:0] rd_bank_q;
    logic [RD_LAT-1:0] v_q, l_q;
    logic [1:0] b_q [RD_LAT];
    logic [1:0] out_bank;

    assign accept = iVALID & ready_q;
    assign rd_issue = state_q == UNLOAD;

    // state and frame counter registers
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q <= LOAD;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
        end
    end

    // next-state logic; cnt wraps to 0 naturally after 2047
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        case (state_q)
            LOAD: begin
                cnt_d = accept ? cnt_q + 11'd1 : cnt_q;
                state_d = (accept && &cnt_q) ? START : LOAD;
            end
            START: state_d = WAIT_FFT;
            WAIT_FFT: state_d = (iFFT_RDY && !rdy_prev_q) ? UNLOAD : WAIT_FFT;
            UNLOAD: begin
                cnt_d = cnt_q + 11'd1;
                state_d = &cnt_q ? DRAIN : UNLOAD;
            end
            DRAIN: state_d = l_q[RD_LAT-1] ? LOAD : DRAIN;
            default: state_d = LOAD;
        endcase
    end

    // registered write port, read port, handshake and status outputs
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            ready_q <= 1'b0;
            busy_q <= 1'b0;
            start_q <= 1'b0;
            rdy_prev_q <= 1'b0;
            data_q <= '0;
            addr_wr_q <= '0;
            we_q <= '0;
            addr_rd_q <= '0;
            re_q <= '0;
            rd_bank_q <= '0;
            rd_last_q <= 1'b0;
        end else begin
            ready_q <= state_d == LOAD;
            busy_q <= state_d != LOAD;
            start_q <= state_q == START;
            rdy_prev_q <= iFFT_RDY;
            we_q <= accept ? 4'b0001 << cnt_q[10:9] : 4'b0000;
            re_q <= rd_issue ? 4'b0001 << cnt_q[10:9] : 4'b0000;
            rd_last_q <= rd_issue & (&cnt_q);
            if (accept) begin
                data_q <= iDATA;
                addr_wr_q <= cnt_q[8:0];
            end
            if (rd_issue) begin
                addr_rd_q <= cnt_q[8:0];
                rd_bank_q <= cnt_q[10:9];
            end
        end
    end

    // bank/valid/last delay line matching the RAM read latency
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            v_q <= '0;
            l_q <= '0;
            for (int i = 0; i < RD_LAT; i++) b_q[i] <= '0;
        end else begin
            v_q[0] <= |re_q;
            l_q[0] <= rd_last_q;
            b_q[0] <= rd_bank_q;
            for (int i = 1; i < RD_LAT; i++) begin
                v_q[i] <= v_q[i-1];
                l_q[i] <= l_q[i-1];
                b_q[i] <= b_q[i-1];
            end
        end
    end

`ifdef FFT_FRAME_OVF_CNT_EN
    logic [15:0] ovf_q;
    // count samples offered while not ready, saturating
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) ovf_q <= '0;
        else if (iVALID && !ready_q && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end
    assign oOVF_CNT = ovf_q;
`else
    assign oOVF_CNT = '0;
`endif

    assign out_bank = b_q[RD_LAT-1];
    assign oOUT_VALID = v_q[RD_LAT-1];
    assign oOUT_LAST = l_q[RD_LAT-1];
    assign oOUT_DATA = !oOUT_VALID ? 16'd0 :
                       out_bank == 2'd0 ? iRD_DATA_0 :
                       out_bank == 2'd1 ? iRD_DATA_1 :
                       out_bank == 2'd2 ? iRD_DATA_2 : iRD_DATA_3;
    assign oREADY = ready_q;
    assign oBUSY = busy_q;
    assign oSTART = start_q;
    assign oDATA = data_q;
    assign oADDR_WR = addr_wr_q;
    assign oWE = we_q;
    assign oADDR_RD = addr_rd_q;
    assign oRE = re_q;
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: randomized frame load/unload bench with a scoreboard model of fft_frame_ctrl (honours FFT_FRAME_OVF_CNT_EN).
module tb_fft_frame_ctrl;
    localparam int LAT = 2;
`ifdef FFT_FRAME_OVF_CNT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        iCLK = 1'b0;
    logic        iRESET = 1'b1;
    logic [15:0] iDATA = '0;
    logic        iVALID = 1'b0;
    logic        iFFT_RDY = 1'b0;
    logic        oREADY, oSTART, oOUT_VALID, oOUT_LAST, oBUSY;
    logic [15:0] oDATA, oOUT_DATA, oOVF_CNT;
    logic [8:0]  oADDR_WR, oADDR_RD;
    logic [3:0]  oWE, oRE;
    logic [15:0] iRD_DATA_0, iRD_DATA_1, iRD_DATA_2, iRD_DATA_3;

    fft_frame_ctrl #(.RD_LAT(LAT)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iDATA(iDATA), .iVALID(iVALID), .oREADY(oREADY),
        .oDATA(oDATA), .oADDR_WR(oADDR_WR), .oWE(oWE), .oSTART(oSTART), .iFFT_RDY(iFFT_RDY),
        .oADDR_RD(oADDR_RD), .oRE(oRE), .iRD_DATA_0(iRD_DATA_0), .iRD_DATA_1(iRD_DATA_1),
        .iRD_DATA_2(iRD_DATA_2), .iRD_DATA_3(iRD_DATA_3), .oOUT_DATA(oOUT_DATA),
        .oOUT_VALID(oOUT_VALID), .oOUT_LAST(oOUT_LAST), .oBUSY(oBUSY), .oOVF_CNT(oOVF_CNT)
    );

    always #5 iCLK = ~iCLK;

    // RAM model: every bank returns bank*1000+addr, LAT cycles after the address
    logic [8:0] ap [LAT] = '{default: '0};
    always @(posedge iCLK) begin
        ap[0] <= oADDR_RD;
        for (int i = 1; i < LAT; i++) ap[i] <= ap[i-1];
    end
    assign iRD_DATA_0 = 16'd0 + {7'd0, ap[LAT-1]};
    assign iRD_DATA_1 = 16'd1000 + {7'd0, ap[LAT-1]};
    assign iRD_DATA_2 = 16'd2000 + {7'd0, ap[LAT-1]};
    assign iRD_DATA_3 = 16'd3000 + {7'd0, ap[LAT-1]};

    int n_tests = 0, n_fail = 0;
    int cyc = 0, wr_idx = 0, rd_idx = 0, out_idx = 0, start_cnt = 0;
    int last_wr_cyc = -10, ready_chk_cyc = -1, ovf_exp = 0;
    bit rd_allowed = 1'b0;
    logic [15:0] exp_q [$];
    int rd_cyc_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge iCLK) cyc++;

    // scoreboard: writes, start pulse, reads and result stream against the frame model
    always @(negedge iCLK) begin
        if (!iRESET) begin
            if (oWE != 4'd0) begin
                if (exp_q.size() == 0) check("wr_unexpected", {28'd0, oWE}, 0);
                else begin
                    check("we_bank", {28'd0, oWE}, 1 << (wr_idx / 512));
                    check("addr_wr", {23'd0, oADDR_WR}, wr_idx % 512);
                    check("wr_data", {16'd0, oDATA}, {16'd0, exp_q.pop_front()});
                    wr_idx++;
                    last_wr_cyc = cyc;
                end
            end
            if (oSTART) begin
                check("start_after_full_frame", wr_idx, 2048);
                check("start_timing", cyc, last_wr_cyc + 1);
                start_cnt++;
            end
            if (oRE != 4'd0) begin
                check("read_after_rdy_edge", {31'd0, rd_allowed}, 1);
                check("re_bank", {28'd0, oRE}, 1 << (rd_idx / 512));
                check("addr_rd", {23'd0, oADDR_RD}, rd_idx % 512);
                rd_cyc_q.push_back(cyc);
                rd_idx++;
            end
            if (oOUT_VALID) begin
                check("out_data", {16'd0, oOUT_DATA}, (out_idx / 512) * 1000 + out_idx % 512);
                check("out_last", {31'd0, oOUT_LAST}, {31'd0, out_idx == 2047});
                if (rd_cyc_q.size() == 0) check("out_without_read", 1, 0);
                else check("out_latency", cyc - rd_cyc_q.pop_front(), LAT);
                if (oOUT_LAST) ready_chk_cyc = cyc + 1;
                out_idx++;
            end else if (oOUT_LAST) check("last_without_valid", 1, 0);
            if (cyc == ready_chk_cyc) begin
                check("ready_after_drain", {31'd0, oREADY}, 1);
                check("busy_after_drain", {31'd0, oBUSY}, 0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {31'd0, oREADY}, 0);
        check({tag, "_we"}, {28'd0, oWE}, 0);
        check({tag, "_re"}, {28'd0, oRE}, 0);
        check({tag, "_start"}, {31'd0, oSTART}, 0);
        check({tag, "_busy"}, {31'd0, oBUSY}, 0);
        check({tag, "_out_valid"}, {31'd0, oOUT_VALID}, 0);
        check({tag, "_out_data"}, {16'd0, oOUT_DATA}, 0);
        check({tag, "_data_addr"}, {7'd0, oDATA, oADDR_WR}, 0);
        check({tag, "_ovf"}, {16'd0, oOVF_CNT}, 0);
    endtask

    // mode 0: random iVALID, 1: toggling 1/0 starting low, 2: back-to-back constant 100
    task automatic load_frame(input int mode, input int n);
        int acc = 0;
        bit tog = 1'b0;
        bit v;
        logic [15:0] d;
        wr_idx = 0; rd_idx = 0; out_idx = 0; rd_allowed = 1'b0;
        rd_cyc_q.delete();
        exp_q.delete();
        while (acc < n) begin
            @(posedge iCLK); #1;
            if (acc == 0 && tog == 1'b0) begin
                check("load_ready", {31'd0, oREADY}, 1);
                check("load_busy", {31'd0, oBUSY}, 0);
            end
            v = mode == 2 ? 1'b1 : mode == 1 ? tog : 1'($urandom % 2);
            d = mode == 2 ? 16'd100 : 16'($urandom);
            tog = ~tog;
            iVALID = v;
            iDATA = d;
            if (v) begin
                exp_q.push_back(d);
                acc++;
            end
        end
        @(posedge iCLK); #1;
        iVALID = 1'b0;
    endtask

    task automatic fft_phase(input bit held);
        int base = start_cnt;
        bit v;
        for (int k = 0; k < 10 && start_cnt == base; k++) begin
            @(posedge iCLK); #1;
        end
        check("start_seen", start_cnt, base + 1);
        check("wait_busy", {31'd0, oBUSY}, 1);
        check("wait_ready", {31'd0, oREADY}, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge iCLK); #1;
            iVALID = 1'(i % 2);
            iDATA = 16'($urandom);
            if (i % 2 == 1) ovf_exp++;
        end
        @(posedge iCLK); #1;
        iVALID = 1'b0;
        check("ovf_in_wait", {16'd0, oOVF_CNT}, OVF_EN ? ovf_exp : 0);
        check("no_read_before_edge", rd_idx, 0);
        if (held) begin
            iFFT_RDY = 1'b0;
            repeat (3) @(posedge iCLK);
            #1;
        end
        rd_allowed = 1'b1;
        iFFT_RDY = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            @(posedge iCLK); #1;
            if (out_idx == 2048) break;
            v = 1'($urandom % 2);
            iVALID = v;
            if (v) ovf_exp++;
        end
        iVALID = 1'b0;
        check("unload_out_count", out_idx, 2048);
        check("unload_read_count", rd_idx, 2048);
        check("ovf_after_unload", {16'd0, oOVF_CNT}, OVF_EN ? ovf_exp : 0);
    endtask

    initial begin
        #2;
        check_all_zero("reset");
        repeat (3) @(posedge iCLK);
        #1;
        iRESET = 1'b0;
        // frame 1: back-to-back 100s, FFT ready already high before launch
        iFFT_RDY = 1'b1;
        load_frame(2, 2048);
        fft_phase(1'b1);
        // frame 2: toggling valid, normal ready edge
        iFFT_RDY = 1'b0;
        load_frame(1, 2048);
        fft_phase(1'b0);
        // frame 3: random valid, reset after 700 samples
        iFFT_RDY = 1'b0;
        load_frame(0, 700);
        @(posedge iCLK); #1;
        check("writes_before_reset", wr_idx, 700);
        iRESET = 1'b1;
        #1;
        check_all_zero("midreset");
        ovf_exp = 0;
        repeat (2) @(posedge iCLK);
        #1;
        check_all_zero("midreset_hold");
        iRESET = 1'b0;
        // frame 4: fresh full frame from bank 0 address 0
        load_frame(0, 2048);
        fft_phase(1'b0);
        repeat (5) @(posedge iCLK);
        #1;
        check("final_busy", {31'd0, oBUSY}, 0);
        check("final_ready", {31'd0, oREADY}, 1);
        check("final_starts", start_cnt, 3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, meaning read latency in cycles from oADDR_RD/oRE to valid iRD_DATA_n (legal 1..4).
REQ-002 SHALL have port iCLK, input, 1 bit: single clock; all logic rising-edge.
REQ-003 SHALL have port iRESET, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port iDATA, input, 16 bits: signed ADC sample.
REQ-005 SHALL have port iVALID, input, 1 bit: sample valid.
REQ-006 SHALL have port oREADY, output, 1 bit: block accepts a sample this cycle.
REQ-007 SHALL have port oDATA, output, 16 bits: sample to FFT RAM write port.
REQ-008 SHALL have port oADDR_WR, output, 9 bits: write address, shared by all banks.
REQ-009 SHALL have port oWE, output, 4 bits: one-hot bank write enable.
REQ-010 SHALL have port oSTART, output, 1 bit: FFT launch pulse.
REQ-011 SHALL have port iFFT_RDY, input, 1 bit: FFT done (level).
REQ-012 SHALL have port oADDR_RD, output, 9 bits: read address, shared by all banks.
REQ-013 SHALL have port oRE, output, 4 bits: one-hot bank read select.
REQ-014 SHALL have ports iRD_DATA_0..3, input, 16 bits each: FFT real-part output per bank.
REQ-015 SHALL have ports oOUT_DATA (output, 16 bits), oOUT_VALID (output, 1 bit) and oOUT_LAST (output, 1 bit): result stream.
REQ-016 SHALL have port oBUSY, output, 1 bit: high in any state except LOAD.
REQ-017 SHALL have port oOVF_CNT, output, 16 bits: dropped-sample count.

Function
REQ-018 SHALL implement states LOAD, START, WAIT_FFT, UNLOAD, DRAIN with an 11-bit counter cnt (2048 points = 4 banks x 512).
REQ-019 LOAD: oREADY=1; each iVALID&oREADY cycle SHALL register oDATA=iDATA, oADDR_WR=cnt[8:0], oWE=one-hot(cnt[10:9]), then cnt+1 (1-cycle latency, oWE high exactly one cycle per sample).
REQ-020 LOAD SHALL hold oWE=0 on cycles without iVALID; cnt SHALL NOT advance.
REQ-021 On acceptance at cnt=2047, the state SHALL go to START, cnt wraps to 0, and oREADY=0 from the next cycle.
REQ-022 START: oSTART=1 for exactly one cycle, then WAIT_FFT.
REQ-023 WAIT_FFT SHALL advance to UNLOAD only on a 0->1 edge of iFFT_RDY sampled in WAIT_FFT; a level already high on entry SHALL be ignored until it falls and rises.
REQ-024 UNLOAD SHALL issue one read per cycle: oADDR_RD=cnt[8:0], oRE=one-hot(cnt[10:9]), cnt 0..2047; after cnt=2047, go to DRAIN with oRE=0.
REQ-025 Bank select SHALL be delayed RD_LAT cycles alongside the read; oOUT_DATA=iRD_DATA_<delayed bank>, oOUT_VALID asserted exactly RD_LAT cycles after each oRE cycle.
REQ-026 oOUT_LAST SHALL be high with the 2048th oOUT_VALID only.
REQ-027 DRAIN SHALL wait until the read pipeline is empty (last oOUT_VALID emitted), then return to LOAD with cnt=0.
REQ-028 iVALID outside LOAD SHALL be dropped (no write, no stall).
REQ-029 oOUT_* SHALL have no backpressure; all outputs registered.

Reset
REQ-030 iRESET high SHALL immediately force LOAD, cnt=0, delay pipeline cleared, oOVF_CNT=0.
REQ-031 During reset all outputs SHALL be 0 (incl. oREADY); oREADY=1 on the first clock edge after release.
REQ-032 Reset mid-frame (any state) SHALL discard the partial frame; no oSTART or oOUT_VALID SHALL follow from it.

Configuration
REQ-033 Macro FFT_FRAME_OVF_CNT_EN defined: oOVF_CNT SHALL increment on each iVALID cycle while oREADY=0, saturating at 16'hFFFF.
REQ-034 Macro FFT_FRAME_OVF_CNT_EN undefined: oOVF_CNT SHALL be constant 0 and no counter logic present.

Verification
REQ-035 2048 back-to-back samples of 16'd100 -> oWE cycles 0001 x512, 0010 x512, 0100 x512, 1000 x512, addr 0..511 each; single oSTART one cycle after last write.
REQ-036 iVALID toggling 1/0 for 4096 cycles -> exactly 2048 writes, oWE never high when iVALID was low.
REQ-037 iFFT_RDY held high before oSTART -> no UNLOAD until it falls and rises; after the rise -> 2048 oOUT_VALID, oOUT_LAST on the last, return to LOAD.
REQ-038 RD_LAT=2, iRD_DATA_n=bank*1000+addr model -> oOUT_DATA sequence 0..511, 1000..1511, 2000..2511, 3000..3511.
REQ-039 iRESET asserted mid-LOAD at cnt=700 -> outputs 0 immediately; the next 2048 samples form a full frame starting at bank 0 addr 0.
REQ-040 With FFT_FRAME_OVF_CNT_EN, 10 iVALID cycles during WAIT_FFT -> oOVF_CNT=10; without the macro -> 0.
